// File: rtl/instr_fetch_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_fetch_sequencer
//
// Byte-wide instruction fetch front end of the 8-bit 5-stage core. Each
// instruction is fetched as two consecutive bytes from 8-bit instruction
// memory at the program counter. The bytes are handed to the downstream
// 16-bit instruction register through its half-load interface: the first
// byte with ir_loadhigh, the second with ir_loadlow. The assembled
// instruction is flagged to decode with instr_valid. A jump redirects the PC.
//
// Parameters
//   RESET_PC      PC value loaded on reset.
//
// Ports
//   clock         system clock, rising-edge active
//   reset         asynchronous, active-high reset
//   stall         decode not ready; holds instr_valid while in ISSUE
//   jump_valid    single-cycle redirect request (wins over everything else)
//   jump_addr     redirect target PC
//   mem_ready     mem_data is valid this cycle for the current mem_addr
//   mem_data      instruction memory read byte
//   mem_rd        read request (HI and LO states)
//   mem_addr      read address, always equal to pc
//   ir_loadhigh   one-cycle strobe: IR high byte <= ir_halfvalue
//   ir_loadlow    one-cycle strobe: IR low byte  <= ir_halfvalue
//   ir_halfvalue  byte presented to the IR with the strobes
//   instr_valid   IR holds a complete instruction (ISSUE state)
//   pc            current fetch address
// -----------------------------------------------------------------------------
module instr_fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [15:0] jump_addr,
   input  logic        mem_ready,
   input  logic [7:0]  mem_data,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   output logic        ir_loadhigh,
   output logic        ir_loadlow,
   output logic [7:0]  ir_halfvalue,
   output logic        instr_valid,
   output logic [15:0] pc
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HI     = 3'd1,
      LO     = 3'd2,
      COMMIT = 3'd3,
      ISSUE  = 3'd4
   } state_t;

   state_t state;

   // Decoded from state so that an asynchronous reset drops the read request
   // and instr_valid immediately, without waiting for a clock edge.
   assign mem_rd      = (state == HI) || (state == LO);
   assign instr_valid = (state == ISSUE);
   assign mem_addr    = pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         ir_halfvalue <= 8'h00;
         ir_loadhigh  <= 1'b0;
         ir_loadlow   <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses; ir_halfvalue keeps its last byte.
         ir_loadhigh <= 1'b0;
         ir_loadlow  <= 1'b0;

         if (jump_valid) begin
            // Redirect discards any half-fetched instruction; mem_data is
            // not captured even if mem_ready is high this cycle.
            pc    <= jump_addr;
            state <= HI;
         end else begin
            case (state)
               IDLE: state <= HI;

               HI: if (mem_ready) begin
                  ir_halfvalue <= mem_data;
                  ir_loadhigh  <= 1'b1;
                  pc           <= pc + 16'd1;   // wraps FFFF -> 0000
                  state        <= LO;
               end

               LO: if (mem_ready) begin
                  ir_halfvalue <= mem_data;
                  ir_loadlow   <= 1'b1;
                  pc           <= pc + 16'd1;
                  state        <= COMMIT;
               end

               // IR captures the low byte at the end of this cycle.
               COMMIT: state <= ISSUE;

               ISSUE: if (!stall) state <= HI;

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
`timescale 1ns/1ps
// Directed bench for instr_fetch_sequencer. Two instances: u0 with
// RESET_PC=0000 driven through the main sequence, u1 with RESET_PC=FFFF used
// for the PC wrap case. A small IR model per instance assembles the 16-bit
// instruction from the half-load strobes.
module tb_instr_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset, reset1;
   logic        stall, jump_valid, mem_ready;
   logic [15:0] jump_addr;

   logic        mem_rd0, ld_hi0, ld_lo0, ivalid0;
   logic [15:0] mem_addr0, pc0;
   logic [7:0]  mem_data0, half0;

   logic        mem_rd1, ld_hi1, ld_lo1, ivalid1;
   logic [15:0] mem_addr1, pc1;
   logic [7:0]  mem_data1, half1;

   logic [7:0]  mem [0:65535];
   logic [15:0] ir0, ir1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   assign mem_data0 = mem[mem_addr0];
   assign mem_data1 = (mem_addr1 == 16'hFFFF) ? 8'h11 :
                      (mem_addr1 == 16'h0000) ? 8'h22 : 8'h00;

   instr_fetch_sequencer #(.RESET_PC(16'h0000)) u0 (
      .clock(clock), .reset(reset), .stall(stall),
      .jump_valid(jump_valid), .jump_addr(jump_addr),
      .mem_ready(mem_ready), .mem_data(mem_data0),
      .mem_rd(mem_rd0), .mem_addr(mem_addr0),
      .ir_loadhigh(ld_hi0), .ir_loadlow(ld_lo0), .ir_halfvalue(half0),
      .instr_valid(ivalid0), .pc(pc0)
   );

   instr_fetch_sequencer #(.RESET_PC(16'hFFFF)) u1 (
      .clock(clock), .reset(reset1), .stall(stall),
      .jump_valid(jump_valid), .jump_addr(jump_addr),
      .mem_ready(mem_ready), .mem_data(mem_data1),
      .mem_rd(mem_rd1), .mem_addr(mem_addr1),
      .ir_loadhigh(ld_hi1), .ir_loadlow(ld_lo1), .ir_halfvalue(half1),
      .instr_valid(ivalid1), .pc(pc1)
   );

   // Downstream 16-bit IR with half-load interface.
   always @(posedge clock) begin
      if (ld_hi0) ir0[15:8] <= half0;
      if (ld_lo0) ir0[7:0]  <= half0;
      if (ld_hi1) ir1[15:8] <= half1;
      if (ld_lo1) ir1[7:0]  <= half1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0000] = 8'hA5; mem[16'h0001] = 8'h3C;
      mem[16'h0002] = 8'h5A; mem[16'h0003] = 8'hC3;
      mem[16'h0004] = 8'h77; mem[16'h0005] = 8'h88;
      mem[16'h1234] = 8'hDE; mem[16'h1235] = 8'hAD;
      mem[16'h0040] = 8'h12; mem[16'h0041] = 8'h34;
      ir0 = 16'h0000; ir1 = 16'h0000;

      reset = 1'b1; reset1 = 1'b1;
      stall = 1'b0; jump_valid = 1'b0; jump_addr = 16'h0000; mem_ready = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_mem_rd", {15'd0, mem_rd0}, 16'd0);
      chk("rst_pc", pc0, 16'h0000);
      chk("rst_ldhi", {15'd0, ld_hi0}, 16'd0);
      chk("rst_ldlo", {15'd0, ld_lo0}, 16'd0);
      chk("rst_half", {8'd0, half0}, 16'h0000);
      chk("rst_ivalid", {15'd0, ivalid0}, 16'd0);

      // Basic fetch A5:3C
      reset = 1'b0;
      #1 chk("idle_no_rd", {15'd0, mem_rd0}, 16'd0);
      tick();
      chk("hi_rd", {15'd0, mem_rd0}, 16'd1);
      chk("hi_addr", mem_addr0, 16'h0000);
      tick();
      chk("ldhi_pulse", {15'd0, ld_hi0}, 16'd1);
      chk("ldhi_val", {8'd0, half0}, 16'h00A5);
      chk("ldhi_pc", pc0, 16'h0001);
      chk("ldhi_no_lo", {15'd0, ld_lo0}, 16'd0);
      tick();
      chk("ldlo_pulse", {15'd0, ld_lo0}, 16'd1);
      chk("ldlo_val", {8'd0, half0}, 16'h003C);
      chk("ldlo_no_hi", {15'd0, ld_hi0}, 16'd0);
      chk("commit_no_rd", {15'd0, mem_rd0}, 16'd0);
      chk("commit_no_valid", {15'd0, ivalid0}, 16'd0);
      tick();
      chk("issue_valid", {15'd0, ivalid0}, 16'd1);
      chk("issue_ir", ir0, 16'hA53C);
      chk("issue_pc", pc0, 16'h0002);

      // Stall for 5 cycles in ISSUE
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {15'd0, ivalid0}, 16'd1);
         chk("stall_no_rd", {15'd0, mem_rd0}, 16'd0);
         chk("stall_pc", pc0, 16'h0002);
      end
      stall = 1'b0;
      tick();
      chk("unstall_rd", {15'd0, mem_rd0}, 16'd1);
      chk("unstall_addr", mem_addr0, 16'h0002);
      chk("unstall_valid", {15'd0, ivalid0}, 16'd0);

      // mem_ready low for 3 cycles in HI
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_rd", {15'd0, mem_rd0}, 16'd1);
         chk("wait_addr", mem_addr0, 16'h0002);
         chk("wait_no_hi", {15'd0, ld_hi0}, 16'd0);
         chk("wait_no_lo", {15'd0, ld_lo0}, 16'd0);
      end
      mem_ready = 1'b1;
      tick();
      chk("wait_ldhi", {15'd0, ld_hi0}, 16'd1);
      chk("wait_ldhi_val", {8'd0, half0}, 16'h005A);
      chk("wait_pc", pc0, 16'h0003);
      tick();
      chk("wait_single_hi", {15'd0, ld_hi0}, 16'd0);
      chk("wait_ldlo", {15'd0, ld_lo0}, 16'd1);
      tick();
      chk("wait_ir", ir0, 16'h5AC3);
      chk("wait_issue", {15'd0, ivalid0}, 16'd1);
      tick();
      chk("next_addr", mem_addr0, 16'h0004);

      // Jump in LO while mem_ready=1
      tick();
      chk("pre_jump_ldhi", {15'd0, ld_hi0}, 16'd1);
      jump_valid = 1'b1; jump_addr = 16'h1234;
      tick();
      jump_valid = 1'b0;
      chk("jump_no_lo", {15'd0, ld_lo0}, 16'd0);
      chk("jump_no_hi", {15'd0, ld_hi0}, 16'd0);
      chk("jump_pc", pc0, 16'h1234);
      chk("jump_half_held", {8'd0, half0}, 16'h0077);
      chk("jump_no_valid", {15'd0, ivalid0}, 16'd0);
      tick();
      chk("jump_ldhi", {8'd0, half0}, 16'h00DE);
      chk("jump_pc1", pc0, 16'h1235);
      tick();
      chk("jump_ldlo", {8'd0, half0}, 16'h00AD);
      chk("jump_lo_no_valid", {15'd0, ivalid0}, 16'd0);
      tick();
      chk("jump_ir", ir0, 16'hDEAD);
      chk("jump_valid", {15'd0, ivalid0}, 16'd1);

      // Jump overrides stall in ISSUE
      stall = 1'b1; jump_valid = 1'b1; jump_addr = 16'h0040;
      tick();
      stall = 1'b0; jump_valid = 1'b0;
      chk("jstall_no_valid", {15'd0, ivalid0}, 16'd0);
      chk("jstall_rd", {15'd0, mem_rd0}, 16'd1);
      chk("jstall_pc", pc0, 16'h0040);

      // Asynchronous reset mid-LO
      tick();
      chk("arst_pre_hi", {15'd0, ld_hi0}, 16'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_rd", {15'd0, mem_rd0}, 16'd0);
      chk("arst_ldhi", {15'd0, ld_hi0}, 16'd0);
      chk("arst_ldlo", {15'd0, ld_lo0}, 16'd0);
      chk("arst_pc", pc0, 16'h0000);
      chk("arst_half", {8'd0, half0}, 16'h0000);
      tick();
      reset = 1'b0;
      #1 chk("arst_idle", {15'd0, mem_rd0}, 16'd0);
      tick();
      chk("arst_restart_rd", {15'd0, mem_rd0}, 16'd1);
      chk("arst_restart_pc", pc0, 16'h0000);
      tick();
      chk("arst_restart_hi", {8'd0, half0}, 16'h00A5);

      // PC wrap on the RESET_PC=FFFF instance
      reset1 = 1'b0;
      #1;
      chk("wrap_rst_pc", pc1, 16'hFFFF);
      tick();
      chk("wrap_hi_addr", mem_addr1, 16'hFFFF);
      tick();
      chk("wrap_ldhi_val", {8'd0, half1}, 16'h0011);
      chk("wrap_pc0", pc1, 16'h0000);
      tick();
      chk("wrap_ldlo_val", {8'd0, half1}, 16'h0022);
      chk("wrap_pc1", pc1, 16'h0001);
      tick();
      chk("wrap_valid", {15'd0, ivalid1}, 16'd1);
      chk("wrap_ir", ir1, 16'h1122);
      chk("wrap_pc_final", pc1, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Byte-wide instruction fetch front end of the 8-bit 5-stage core.
- Reads two consecutive bytes from 8-bit instruction memory at the program counter.
- Drives the half-load interface of the downstream 16-bit instruction register: loadhigh with the first byte, loadlow with the second.
- Flags the assembled instruction to decode, honours decode stall, and redirects the PC on a jump.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  decode not ready; holds instr_valid.
jump_valid  input  1  redirect request, single-cycle.
jump_addr  input  16  redirect target PC.
mem_ready  input  1  mem_data valid this cycle for the current mem_addr.
mem_data  input  8  instruction memory read byte.
mem_rd  output  1  read request.
mem_addr  output  16  read address; always equals pc.
ir_loadhigh  output  1  one-cycle load strobe for the IR high byte.
ir_loadlow  output  1  one-cycle load strobe for the IR low byte.
ir_halfvalue  output  8  byte presented to the IR with the strobes.
instr_valid  output  1  IR holds a complete instruction.
pc  output  16  current fetch address.

Behaviour:
- Reset is asynchronous and active-high; all state updates on rising edge of clock.
- Reset values while reset=1 (takes effect immediately, no clock needed):
  - state=IDLE, pc=RESET_PC, ir_halfvalue=8'h00.
  - mem_rd, ir_loadhigh, ir_loadlow, instr_valid all 0.
- Combinational outputs:
  - mem_addr = pc.
  - mem_rd = 1 only in states HI and LO.
  - instr_valid = 1 only in state ISSUE.
- ir_loadhigh, ir_loadlow and ir_halfvalue are registered. The strobes are never both 1.
- FSM states and transitions (jump rule below overrides all of these):
  - IDLE: unconditionally -> HI.
  - HI: wait for mem_ready.
    - On mem_ready=1: ir_halfvalue<=mem_data, ir_loadhigh<=1 for the next cycle only, pc<=pc+1, -> LO.
  - LO: wait for mem_ready.
    - On mem_ready=1: ir_halfvalue<=mem_data, ir_loadlow<=1 for the next cycle only, pc<=pc+1, -> COMMIT.
  - COMMIT: the IR captures the low byte at the end of this cycle. -> ISSUE.
  - ISSUE: instr_valid=1.
    - stall=1: remain in ISSUE, instr_valid held.
    - stall=0: -> HI.
- ir_halfvalue holds its last value while no strobe is active.
- Latency with mem_ready tied high: 4 cycles per instruction (HI, LO, COMMIT, ISSUE). The first mem_rd is asserted one cycle after reset deassertion.
- Jump (jump_valid=1 at a rising edge, in any state):
  - pc<=jump_addr, state<=HI.
  - ir_loadhigh<=0, ir_loadlow<=0; mem_data is not captured, even if mem_ready=1 the same cycle.
  - Any in-flight half-instruction is discarded; the IR may hold a stale high byte, which is overwritten by the next HI fetch.
  - In ISSUE, jump overrides stall.
  - Jump in IDLE -> HI with pc=jump_addr.
- PC arithmetic: 16-bit unsigned, wraps from 16'hFFFF to 16'h0000 with no flag. An instruction may straddle the wrap (high byte at FFFF, low byte at 0000).
- mem_ready is ignored outside HI and LO.
- Reset asserted mid-fetch: immediate return to reset values. Any strobe in progress is cancelled asynchronously; the pending read is dropped.
- No X propagation: every register has a defined reset value. No latches.

Test Plan:
- Reset, RESET_PC=0, mem_ready=1, mem[0]=8'hA5, mem[1]=8'h3C, stall=0 -> ir_loadhigh pulses with ir_halfvalue=A5; next cycle ir_loadlow pulses with 3C; instr_valid=1 two cycles after the loadhigh cycle; pc=2; IR model reads 16'hA53C.
- mem_ready held 0 for 3 cycles in HI, then 1 -> mem_rd=1 and mem_addr=pc constant throughout the wait; a single ir_loadhigh pulse; no strobe during the wait.
- stall=1 for 5 cycles while in ISSUE -> instr_valid stays 1, mem_rd=0, pc unchanged; stall=0 -> HI next cycle, mem_addr=2.
- jump_valid=1 with jump_addr=16'h1234 in LO while mem_ready=1 -> no ir_loadlow; pc=1234; next fetch reads 1234 then 1235; instr_valid asserted only after both new bytes are loaded.
- RESET_PC=16'hFFFF, memory returns FF:11 and 00:22 -> IR=16'h1122, pc=16'h0001 after the instruction.
- reset asserted mid-LO between clock edges -> mem_rd, ir_loadhigh and ir_loadlow drop without a clock edge; pc=RESET_PC; after release, fetch restarts from IDLE.
